// File: rtl/s_to_p_pkg.sv
// s_to_p_pkg: shared constants and helpers for the parametrised
// serial-to-parallel converter.
//   out_w(in_w, beats)        : assembled word width, IN_W*BEATS
//   cnt_w(beats)              : width of the beat count, $clog2(BEATS+1)
//   lane_idx(k, beats, msb)   : output lane that beat k lands in
package s_to_p_pkg;

  localparam int DEF_IN_W      = 1;
  localparam int DEF_BEATS     = 6;
  localparam bit DEF_MSB_FIRST = 1'b0;

  function automatic int out_w(input int in_w, input int beats);
    return in_w * beats;
  endfunction

  function automatic int cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

  // Beat 0 goes to lane 0 (LSB-first) or to the top lane (MSB-first).
  function automatic int unsigned lane_idx(input int unsigned k,
                                           input int unsigned beats,
                                           input bit msb_first);
    return msb_first ? (beats - 1 - k) : k;
  endfunction

endpackage

// File: rtl/s_to_p_hold.sv
// s_to_p_hold: output holding register with valid/ready handoff.
//   clk, rst           : clock, synchronous active-high reset
//   load               : a word closes this cycle (only raised while ready_a=1)
//   word, cnt, last    : word contents to capture on load
//   ready_a            : upstream may advance (no undelivered word, or it leaves now)
//   valid_b/data_b/cnt_b/last_b : held word, stable until valid_b && ready_b
//   ready_b            : consumer accepts the held word
module s_to_p_hold #(
  parameter int OUT_W = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] word,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last,
  output logic             ready_a,
  output logic             valid_b,
  output logic [OUT_W-1:0] data_b,
  output logic [CNT_W-1:0] cnt_b,
  output logic             last_b,
  input  logic             ready_b
);

  assign ready_a = !valid_b || ready_b;

  // A load in the same cycle as a handoff replaces the word directly, which
  // gives one word every BEATS cycles. Payload is left untouched on a plain
  // handoff so it does not toggle while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_b <= 1'b0;
      data_b  <= '0;
      cnt_b   <= '0;
      last_b  <= 1'b0;
    end else if (load) begin
      valid_b <= 1'b1;
      data_b  <= word;
      cnt_b   <= cnt;
      last_b  <= last;
    end else if (ready_b) begin
      valid_b <= 1'b0;
    end
  end

endmodule

// File: rtl/s_to_p_param.sv
// s_to_p_param: packs BEATS beats of IN_W bits into one IN_W*BEATS word.
//   clk, rst        : clock, synchronous active-high reset
//   valid_a, data_a : input beat, accepted when valid_a && ready_a
//   last_a          : beat closes the current word early (zero-padded)
//   ready_a         : beat can be accepted this cycle
//   valid_b, data_b : assembled word with valid/ready handoff
//   cnt_b           : number of valid beats in data_b
//   last_b          : word was closed by last_a before it filled
//   ready_b         : consumer accepts the word
module s_to_p_param
  import s_to_p_pkg::*;
#(
  parameter  int IN_W      = DEF_IN_W,
  parameter  int BEATS     = DEF_BEATS,
  parameter  bit MSB_FIRST = DEF_MSB_FIRST,
  localparam int OUT_W     = out_w(IN_W, BEATS),
  localparam int CNT_W     = cnt_w(BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_a,
  input  logic [IN_W-1:0]  data_a,
  input  logic             last_a,
  output logic             ready_a,
  output logic             valid_b,
  output logic [OUT_W-1:0] data_b,
  output logic [CNT_W-1:0] cnt_b,
  output logic             last_b,
  input  logic             ready_b
);

  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] k_q;
  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] word_d;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             at_last;
  logic             close;
  logic             last_d;
  int unsigned      lane;

  assign accept  = valid_a && ready_a;
  assign at_last = (k_q == K_LAST);
  assign close   = accept && (at_last || last_a);
  assign lane    = lane_idx(32'(k_q), BEATS, MSB_FIRST);
  assign cnt_d   = k_q + 1'b1;
  // A last_a on the final beat is just a full word.
  assign last_d  = last_a && !at_last;

  // Assembly register with the current beat merged into its lane; this is
  // also the word handed to the holding register on close.
  for (genvar j = 0; j < BEATS; j++) begin : g_lane
    localparam int unsigned LJ = j;
    assign word_d[j*IN_W +: IN_W] = (accept && (lane == LJ)) ? data_a
                                                            : asm_q[j*IN_W +: IN_W];
  end

  // Clearing on close is what zero-pads partial words and keeps bits of one
  // word out of the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      asm_q <= '0;
    end else if (close) begin
      k_q   <= '0;
      asm_q <= '0;
    end else if (accept) begin
      k_q   <= k_q + 1'b1;
      asm_q <= word_d;
    end
  end

  s_to_p_hold #(
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (close),
    .word   (word_d),
    .cnt    (cnt_d),
    .last   (last_d),
    .ready_a(ready_a),
    .valid_b(valid_b),
    .data_b (data_b),
    .cnt_b  (cnt_b),
    .last_b (last_b),
    .ready_b(ready_b)
  );

endmodule

// File: tb/tb_s_to_p_param.sv
module tb_s_to_p_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  // default DUT: IN_W=1, BEATS=6, LSB-first
  logic       va = 1'b0, la = 1'b0, rb = 1'b1;
  logic [0:0] da = '0;
  logic       ra, vb, lb;
  logic [5:0] db;
  logic [2:0] cb;
  // second DUT: IN_W=4, BEATS=2, MSB-first
  logic       va2 = 1'b0, la2 = 1'b0, rb2 = 1'b1;
  logic [3:0] da2 = '0;
  logic       ra2, vb2, lb2;
  logic [7:0] db2;
  logic [1:0] cb2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s_to_p_param dut (
    .clk(clk), .rst(rst), .valid_a(va), .data_a(da), .last_a(la), .ready_a(ra),
    .valid_b(vb), .data_b(db), .cnt_b(cb), .last_b(lb), .ready_b(rb)
  );

  s_to_p_param #(.IN_W(4), .BEATS(2), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .valid_a(va2), .data_a(da2), .last_a(la2), .ready_a(ra2),
    .valid_b(vb2), .data_b(db2), .cnt_b(cb2), .last_b(lb2), .ready_b(rb2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send1(input logic d, input logic l);
    va = 1'b1; da = d; la = l;
    step();
    va = 1'b0; la = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic l);
    va2 = 1'b1; da2 = d; la2 = l;
    step();
    va2 = 1'b0; la2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", vb); end
    checks++; if (db !== 6'h00) begin errors++; $display("FAIL reset_data_b: got %h want 00", db); end
    checks++; if (cb !== 3'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d want 0", cb); end
    checks++; if (lb !== 1'b0) begin errors++; $display("FAIL reset_last_b: got %b want 0", lb); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", ra); end
    checks++; if (vb2 !== 1'b0 || db2 !== 8'h00) begin errors++; $display("FAIL reset_dut2: got v=%b d=%h want 0/00", vb2, db2); end
  endtask

  task automatic test_basic();
    logic [5:0] w = 6'b001101;  // beat i = w[i]: 1,0,1,1,0,0
    rb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send1(w[i], 1'b0);
      if (i < 5) begin
        checks++; if (vb !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d: got %b want 0", i, vb); end
      end
    end
    checks++; if (vb !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", vb); end
    checks++; if (db !== 6'b001101) begin errors++; $display("FAIL basic_data: got %b want 001101", db); end
    checks++; if (cb !== 3'd6) begin errors++; $display("FAIL basic_cnt: got %0d want 6", cb); end
    checks++; if (lb !== 1'b0) begin errors++; $display("FAIL basic_last: got %b want 0", lb); end
    step();
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", vb); end
    checks++; if (db !== 6'b001101) begin errors++; $display("FAIL basic_data_hold: got %b want 001101", db); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] w1 = 6'b111111;
    logic [5:0] w2 = 6'b000010;
    logic       d;
    rb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = (i < 6) ? w1[i] : w2[i-6];
      send1(d, 1'b0);
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL b2b_ready_a beat %0d: got %b want 1", i, ra); end
      if (i == 5) begin
        checks++; if (vb !== 1'b1 || db !== 6'h3F) begin errors++; $display("FAIL b2b_word1: got v=%b d=%b want 1/111111", vb, db); end
      end else if (i == 11) begin
        checks++; if (vb !== 1'b1 || db !== 6'h02) begin errors++; $display("FAIL b2b_word2: got v=%b d=%b want 1/000010", vb, db); end
      end else begin
        checks++; if (vb !== 1'b0) begin errors++; $display("FAIL b2b_valid beat %0d: got %b want 0", i, vb); end
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [5:0] w = 6'b010110;
    rb = 1'b0;
    for (int i = 0; i < 6; i++) send1(w[i], 1'b0);
    va = 1'b1; da = 1'b1;  // offered beat that must wait
    for (int c = 0; c < 3; c++) begin
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL bp_ready_a cycle %0d: got %b want 0", c, ra); end
      checks++; if (vb !== 1'b1 || db !== 6'h16 || cb !== 3'd6) begin errors++; $display("FAIL bp_hold cycle %0d: got v=%b d=%b c=%0d want 1/010110/6", c, vb, db, cb); end
      step();
    end
    rb = 1'b1;
    #1;
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_a_release: got %b want 1", ra); end
    step();  // handoff and the held beat accepted as beat 0
    va = 1'b0;
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL bp_handoff: got %b want 0", vb); end
    for (int i = 0; i < 5; i++) send1(1'b0, 1'b0);
    checks++; if (vb !== 1'b1 || db !== 6'h01 || cb !== 3'd6) begin errors++; $display("FAIL bp_next_word: got v=%b d=%b c=%0d want 1/000001/6", vb, db, cb); end
    step();
  endtask

  task automatic test_partial();
    logic [5:0] w  = 6'b100100;
    logic [5:0] w3 = 6'b100001;
    rb = 1'b1;
    send1(1'b1, 1'b0);
    send1(1'b1, 1'b0);
    send1(1'b0, 1'b1);
    checks++; if (vb !== 1'b1 || db !== 6'b000011) begin errors++; $display("FAIL part_word: got v=%b d=%b want 1/000011", vb, db); end
    checks++; if (cb !== 3'd3 || lb !== 1'b1) begin errors++; $display("FAIL part_cnt_last: got c=%0d l=%b want 3/1", cb, lb); end
    for (int i = 0; i < 6; i++) send1(w[i], 1'b0);
    checks++; if (vb !== 1'b1 || db !== 6'b100100 || cb !== 3'd6 || lb !== 1'b0) begin errors++; $display("FAIL part_after: got v=%b d=%b c=%0d l=%b want 1/100100/6/0", vb, db, cb, lb); end
    for (int i = 0; i < 6; i++) send1(w3[i], i == 5);
    checks++; if (vb !== 1'b1 || db !== 6'b100001 || cb !== 3'd6 || lb !== 1'b0) begin errors++; $display("FAIL last_on_full: got v=%b d=%b c=%0d l=%b want 1/100001/6/0", vb, db, cb, lb); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [5:0] w = 6'b101010;
    int words = 0;
    rb = 1'b1;
    for (int i = 0; i < 4; i++) send1(1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (vb !== 1'b0 || db !== 6'h00 || cb !== 3'd0 || lb !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got v=%b d=%b c=%0d l=%b want all 0", vb, db, cb, lb); end
    for (int i = 0; i < 6; i++) begin
      send1(w[i], 1'b0);
      if (vb === 1'b1) words++;
    end
    checks++; if (words !== 1) begin errors++; $display("FAIL rstmid_words: got %0d want 1", words); end
    checks++; if (db !== 6'b101010 || cb !== 3'd6) begin errors++; $display("FAIL rstmid_word: got d=%b c=%0d want 101010/6", db, cb); end
    step();
  endtask

  task automatic test_msb_first();
    rb2 = 1'b1;
    send2(4'hA, 1'b0);
    send2(4'h5, 1'b0);
    checks++; if (vb2 !== 1'b1 || db2 !== 8'hA5 || cb2 !== 2'd2 || lb2 !== 1'b0) begin errors++; $display("FAIL msb_full: got v=%b d=%h c=%0d l=%b want 1/a5/2/0", vb2, db2, cb2, lb2); end
    send2(4'hC, 1'b1);
    checks++; if (vb2 !== 1'b1 || db2 !== 8'hC0 || cb2 !== 2'd1 || lb2 !== 1'b1) begin errors++; $display("FAIL msb_partial: got v=%b d=%h c=%0d l=%b want 1/c0/1/1", vb2, db2, cb2, lb2); end
    step();
    checks++; if (vb2 !== 1'b0) begin errors++; $display("FAIL msb_drop: got %b want 0", vb2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_partial();
    test_reset_mid();
    test_msb_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
